// File: rtl/adder_share_pkg.sv
// Shared constants, ID-width helper and result record for adder_share_arb.
// The optional carry-out port is enabled by ADDER_SHARE_ARB_OVF_EN.
package adder_share_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_NUM_REQ = 4;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_DATA_W-1:0] sum;
        logic [DEF_ID_W-1:0]   id;
        logic                  ovf;
    } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer advances past winner.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin : search
        int   j;
        logic found;
        j       = 0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin shared adder with a registered, ID-tagged result.
// Define ADDER_SHARE_ARB_OVF_EN to add the registered carry-out port out_ovf.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_sum,
    output logic [ID_W-1:0]           out_id
`ifdef ADDER_SHARE_ARB_OVF_EN
    ,
    output logic                      out_ovf
`endif
);

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                can_issue;
    logic [NUM_REQ-1:0]  req_gate;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                fire;
    logic [DATA_W-1:0]   a_sel, b_sel;

    // Gating the requests (not the grants) keeps the pointer frozen on stall.
    assign can_issue = !valid_q || out_ready;
    assign req_gate  = req_valid & {NUM_REQ{can_issue && !rst}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_gate),
        .advance (fire),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign fire      = |gnt;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = a_sel | req_a[i*DATA_W +: DATA_W];
                b_sel = b_sel | req_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ADDER_SHARE_ARB_OVF_EN
    logic [DATA_W:0] sum_w;
    logic            ovf_q, ovf_d;

    assign sum_w = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        ovf_d = ovf_q;
        if (fire) begin
            ovf_d = sum_w[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic [DATA_W-1:0] sum_w;

    assign sum_w = a_sel + b_sel;
`endif

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        id_d    = id_q;
        if (fire) begin
            valid_d = 1'b1;
            sum_d   = sum_w[DATA_W-1:0];
            id_d    = gnt_idx;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed vector bench for adder_share_arb (4 requesters, 16-bit).
// Each vector is one cycle: inputs, combinational ready, registered outputs.
module tb_adder_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [1:0]  out_id;
`ifdef ADDER_SHARE_ARB_OVF_EN
    logic        out_ovf;
`endif

    adder_share_arb #(
        .NUM_REQ (4),
        .DATA_W  (16),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef ADDER_SHARE_ARB_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [15:0] a0, b0, a2, b2;
        logic [3:0]  erdy;
        logic        ev;
        logic [15:0] esum;
        logic [1:0]  eid;
        logic        eovf;
    } vec_t;

    localparam int NV = 29;
    vec_t vt[NV];
    int   n_vec;
    int   n_bad;

    function automatic vec_t V(
        input logic r, input logic [3:0] vl, input logic o,
        input logic [15:0] a0, input logic [15:0] b0,
        input logic [15:0] a2, input logic [15:0] b2,
        input logic [3:0] er, input logic ev,
        input logic [15:0] es, input logic [1:0] ei, input logic eo);
        vec_t t;
        t.rst = r;   t.valid = vl; t.ordy = o;
        t.a0 = a0;   t.b0 = b0;    t.a2 = a2;  t.b2 = b2;
        t.erdy = er; t.ev = ev;    t.esum = es;
        t.eid = ei;  t.eovf = eo;
        return t;
    endfunction

    task automatic drive(input logic [3:0] vl, input logic o,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a2, input logic [15:0] b2);
        req_valid = vl;
        out_ready = o;
        req_a = {16'h0300, a2, 16'h0100, a0};
        req_b = {16'h0001, b2, 16'h0001, b0};
    endtask

    task automatic check(input string nm, input logic [3:0] er,
                         input logic ev, input logic [15:0] es,
                         input logic [1:0] ei, input logic eo);
        logic bad;
        n_vec++;
        bad = (req_ready !== er) || (out_valid !== ev)
           || (out_sum !== es) || (out_id !== ei);
`ifdef ADDER_SHARE_ARB_OVF_EN
        bad = bad || (out_ovf !== eo);
`endif
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b v=%b sum=%h id=%0d exp rdy=%b v=%b sum=%h id=%0d ovf=%b",
                     nm, req_ready, out_valid, out_sum, out_id,
                     er, ev, es, ei, eo);
        end
    endtask

    initial begin
        logic got;
        int   waited;
        n_vec = 0;
        n_bad = 0;

        // Fill: rst, valid, ordy, a0, b0, a2, b2 | rdy, v, sum, id, ovf
        vt[0]  = V(1, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 0, 16'h0000, 0, 0);
        vt[1]  = V(0, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h1, 0, 16'h0000, 0, 0);
        vt[2]  = V(0, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h2, 1, 16'h0001, 0, 0);
        vt[3]  = V(0, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h4, 1, 16'h0101, 1, 0);
        vt[4]  = V(0, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h8, 1, 16'h0201, 2, 0);
        vt[5]  = V(0, 4'hF, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h1, 1, 16'h0301, 3, 0);
        vt[6]  = V(0, 4'h0, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0001, 0, 0);
        vt[7]  = V(0, 4'h0, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 0, 16'h0001, 0, 0);
        vt[8]  = V(0, 4'h1, 0, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h1, 0, 16'h0001, 0, 0);
        vt[9]  = V(0, 4'h1, 0, 16'h0010, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0001, 0, 0);
        vt[10] = V(0, 4'h1, 0, 16'h0010, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0001, 0, 0);
        vt[11] = V(0, 4'h1, 0, 16'h0010, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0001, 0, 0);
        vt[12] = V(0, 4'h1, 1, 16'h0010, 16'h0001, 16'h0200, 16'h0001, 4'h1, 1, 16'h0001, 0, 0);
        vt[13] = V(0, 4'h8, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h8, 1, 16'h0011, 0, 0);
        vt[14] = V(0, 4'hA, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h2, 1, 16'h0301, 3, 0);
        vt[15] = V(0, 4'h8, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h8, 1, 16'h0101, 1, 0);
        vt[16] = V(0, 4'h1, 1, 16'hFFFF, 16'h0002, 16'h0200, 16'h0001, 4'h1, 1, 16'h0301, 3, 0);
        vt[17] = V(0, 4'h1, 1, 16'h7FFF, 16'h0001, 16'h0200, 16'h0001, 4'h1, 1, 16'h0001, 0, 1);
        vt[18] = V(0, 4'h4, 1, 16'h0000, 16'h0001, 16'h0000, 16'h0002, 4'h4, 1, 16'h8000, 0, 0);
        vt[19] = V(0, 4'h4, 1, 16'h0000, 16'h0001, 16'h0010, 16'h0002, 4'h4, 1, 16'h0002, 2, 0);
        vt[20] = V(0, 4'h4, 1, 16'h0000, 16'h0001, 16'h0020, 16'h0002, 4'h4, 1, 16'h0012, 2, 0);
        vt[21] = V(0, 4'h4, 1, 16'h0000, 16'h0001, 16'h0030, 16'h0002, 4'h4, 1, 16'h0022, 2, 0);
        vt[22] = V(0, 4'h4, 1, 16'h0000, 16'h0001, 16'h0040, 16'h0002, 4'h4, 1, 16'h0032, 2, 0);
        vt[23] = V(0, 4'h0, 0, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0042, 2, 0);
        vt[24] = V(0, 4'h0, 0, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0042, 2, 0);
        vt[25] = V(1, 4'hF, 0, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0042, 2, 0);
        vt[26] = V(0, 4'hA, 0, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h2, 0, 16'h0000, 0, 0);
        vt[27] = V(0, 4'h0, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 1, 16'h0101, 1, 0);
        vt[28] = V(0, 4'h0, 1, 16'h0000, 16'h0001, 16'h0200, 16'h0001, 4'h0, 0, 16'h0101, 1, 0);

        rst = 1'b1;
        drive(4'h0, 1'b1, 16'h0000, 16'h0001, 16'h0200, 16'h0001);
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            drive(vt[i].valid, vt[i].ordy, vt[i].a0, vt[i].b0,
                  vt[i].a2, vt[i].b2);
            #2;
            check($sformatf("vec%0d", i), vt[i].erdy, vt[i].ev,
                  vt[i].esum, vt[i].eid, vt[i].eovf);
        end

        // Pointer sits at 2 after vec26; lone req1 must win with no wait.
        @(negedge clk);
        drive(4'h2, 1'b1, 16'h0000, 16'h0001, 16'h0200, 16'h0001);
        got    = 1'b0;
        waited = 0;
        repeat (4) begin
            if (!got) begin
                #2;
                if (req_ready[1]) begin
                    got = 1'b1;
                end else begin
                    @(negedge clk);
                    waited++;
                end
            end
        end
        n_vec++;
        if (!got || waited != 0) begin
            n_bad++;
            $display("FAIL grant_wait: got granted=%b after %0d cycles exp granted=1 after 0",
                     got, waited);
        end

        @(negedge clk);
        drive(4'h0, 1'b1, 16'h0000, 16'h0001, 16'h0200, 16'h0001);
        #2;
        check("post_grant", 4'h0, 1'b1, 16'h0101, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
